cnn_chip: RTL and testbench

//  Conv layer engine: streams one CIN-channel ROWxCOL image plus 3x3 weights for COUT filters, computes

---
 rtl/cnn_chip.sv | 212 +++++++++++++++++++++
 tb/tb_cnn_chip.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_chip.sv
// Streaming 3x3 "same" convolution engine: loads one CIN-channel image and its weights,
// then emits ReLU + shift-quantized + 2x2 max-pooled bytes for every output channel.
module cnn_chip #(
  parameter int PEA_NUM    = 32,
  parameter int FILTER_NUM = 32,
  parameter int CIN        = 4,
  parameter int COUT       = 32,
  parameter int ROW        = 128,
  parameter int COL        = 128,
  parameter int QSHIFT     = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [PEA_NUM*8-1:0]          data_in,
  input  logic [COUT*24-1:0]            weight_in,
  output logic [FILTER_NUM*PEA_NUM*8-1:0] sum,
  output logic                          sum_reg_valid,
  output logic [COUT*8-1:0]             ans,
  output logic [2:0]                    curr_state_or_output,
  output logic [7:0]                    OR_pxl_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int RW = $clog2(ROW);
  localparam int CW = $clog2(COL);
  localparam int LW = $clog2(ROW*COL);
  localparam logic [LW-1:0] LD_LAST  = LW'(ROW*COL-1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL-1);
  localparam logic [RW-2:0] PR_LAST  = (RW-1)'(ROW/2-1);
  localparam logic [CW-2:0] PC_LAST  = (CW-1)'(COL/2-1);

  logic [2:0]    r_state;
  logic [LW-1:0] r_ldCnt;
  logic [RW-1:0] r_ldRow;
  logic [CW-1:0] r_ldCol;
  logic [RW-2:0] r_pr;
  logic [CW-2:0] r_pc;
  logic [1:0]    r_sub;
  logic [7:0]    r_pxlCnt;
  logic          r_sumValid;
  logic [FILTER_NUM*PEA_NUM*8-1:0] r_sum;
  logic [COUT*8-1:0] r_qmax;
  logic [COUT*8-1:0] r_ans;

  logic [7:0]        r_mem [CIN][ROW][COL];
  logic signed [7:0] r_w   [COUT][CIN][3][3];

  logic [RW-1:0] w_posRow;
  logic [CW-1:0] w_posCol;
  logic [FILTER_NUM*PEA_NUM*8-1:0] w_sum;
  logic [COUT*8-1:0] w_q;
  logic signed [23:0] w_chanAcc;
  logic signed [23:0] w_acc;
  logic signed [23:0] w_shift;
  logic signed [16:0] w_prod;
  logic [7:0]    w_pix;
  int            w_y;
  int            w_x;
  logic          w_unusedLanes;

  assign w_unusedLanes = ^data_in;
  assign w_posRow = {r_pr, r_sub[1]};
  assign w_posCol = {r_pc, r_sub[0]};

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // One full conv position per cycle: every filter, every channel, all nine taps.
  always_comb begin
    w_sum     = '0;
    w_q       = '0;
    w_chanAcc = '0;
    w_acc     = '0;
    w_shift   = '0;
    w_prod    = '0;
    w_pix     = '0;
    w_y       = 0;
    w_x       = 0;
    for (int o = 0; o < COUT; o++) begin
      w_acc = '0;
      for (int c = 0; c < CIN; c++) begin
        w_chanAcc = '0;
        for (int r = 0; r < 3; r++) begin
          for (int s = 0; s < 3; s++) begin
            w_y   = int'(w_posRow) + r - 1;
            w_x   = int'(w_posCol) + s - 1;
            w_pix = '0;
            if (w_y >= 0 && w_y < ROW && w_x >= 0 && w_x < COL)
              w_pix = r_mem[c][RW'(w_y)][CW'(w_x)];
            w_prod    = $signed({1'b0, w_pix}) * r_w[o][c][r][s];
            w_chanAcc = w_chanAcc + 24'(w_prod);
          end
        end
        w_acc = w_acc + w_chanAcc;
        if (w_chanAcc > 24'sd127)
          w_sum[(o*PEA_NUM+c)*8 +: 8] = 8'h7f;
        else if (w_chanAcc < -24'sd128)
          w_sum[(o*PEA_NUM+c)*8 +: 8] = 8'h80;
        else
          w_sum[(o*PEA_NUM+c)*8 +: 8] = w_chanAcc[7:0];
      end
      if (!w_acc[23]) begin
        w_shift = w_acc >>> QSHIFT;
        w_q[o*8 +: 8] = (w_shift > 24'sd255) ? 8'hff : w_shift[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      for (int c = 0; c < CIN; c++)
        r_mem[c][r_ldRow][r_ldCol] <= data_in[c*8 +: 8];
      for (int k = 0; k < 3*CIN; k++) begin
        if (r_ldCnt == LW'(k)) begin
          for (int o = 0; o < COUT; o++)
            for (int s = 0; s < 3; s++)
              r_w[o][k/3][k%3][s] <= weight_in[o*24 + (2-s)*8 +: 8];
        end
      end
    end
  end

  // Load walk: first two rows interleaved column-wise, then a serpentine over the remaining rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ldCnt    <= '0;
      r_ldRow    <= '0;
      r_ldCol    <= '0;
      r_pr       <= '0;
      r_pc       <= '0;
      r_sub      <= '0;
      r_pxlCnt   <= '0;
      r_sumValid <= 1'b0;
      r_sum      <= '0;
      r_qmax     <= '0;
      r_ans      <= '0;
    end else begin
      r_sumValid <= 1'b0;
      case (r_state)
        S_IDLE: if (start) r_state <= S_ARM;
        S_ARM: begin
          r_state  <= S_LOAD;
          r_ldCnt  <= '0;
          r_ldRow  <= '0;
          r_ldCol  <= '0;
          r_pr     <= '0;
          r_pc     <= '0;
          r_sub    <= '0;
          r_pxlCnt <= '0;
        end
        S_LOAD: begin
          r_ldCnt <= r_ldCnt + LW'(1);
          if (r_ldRow < RW'(2)) begin
            if (r_ldRow == '0) r_ldRow <= RW'(1);
            else if (r_ldCol == COL_LAST) r_ldRow <= RW'(2);
            else begin
              r_ldRow <= '0;
              r_ldCol <= r_ldCol + CW'(1);
            end
          end else if (!r_ldRow[0]) begin
            if (r_ldCol == '0) r_ldRow <= r_ldRow + RW'(1);
            else r_ldCol <= r_ldCol - CW'(1);
          end else begin
            if (r_ldCol == COL_LAST) r_ldRow <= r_ldRow + RW'(1);
            else r_ldCol <= r_ldCol + CW'(1);
          end
          if (r_ldCnt == LD_LAST) r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          r_sum      <= w_sum;
          r_sumValid <= 1'b1;
          r_sub      <= r_sub + 2'd1;
          for (int o = 0; o < COUT; o++) begin
            if (r_sub == 2'd0) r_qmax[o*8 +: 8] <= w_q[o*8 +: 8];
            else r_qmax[o*8 +: 8] <= max8(r_qmax[o*8 +: 8], w_q[o*8 +: 8]);
            if (r_sub == 2'd3) r_ans[o*8 +: 8] <= max8(r_qmax[o*8 +: 8], w_q[o*8 +: 8]);
          end
          if (r_sub == 2'd3) r_state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          r_pxlCnt <= r_pxlCnt + 8'd1;
          r_state  <= S_COMPUTE;
          if (r_pc == PC_LAST) begin
            r_pc <= '0;
            if (r_pr == PR_LAST) r_state <= S_DONE;
            else r_pr <= r_pr + (RW-1)'(1);
          end else begin
            r_pc <= r_pc + (CW-1)'(1);
          end
        end
        S_DONE: if (!start) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sum                  = r_sum;
  assign sum_reg_valid        = r_sumValid;
  assign ans                  = r_ans;
  assign curr_state_or_output = r_state;
  assign OR_pxl_cnt           = r_pxlCnt;

endmodule

// File: tb/tb_cnn_chip.sv
// Self-checking bench for cnn_chip on a 4x4 image: an arithmetic convolution/pool model
// checked every meaningful cycle, plus hand-computed literal expectations per frame.
module tb_cnn_chip;

  localparam int PEA  = 32;
  localparam int FN   = 32;
  localparam int CIN  = 4;
  localparam int COUT = 32;
  localparam int ROW  = 4;
  localparam int COL  = 4;
  localparam int QS   = 0;
  localparam int NPIX = ROW*COL;
  localparam int NOUT = (ROW/2)*(COL/2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [PEA*8-1:0]   data_in = '0;
  logic [COUT*24-1:0] weight_in = '0;
  logic [FN*PEA*8-1:0] sum;
  logic               sum_reg_valid;
  logic [COUT*8-1:0]  ans;
  logic [2:0]         curr_state_or_output;
  logic [7:0]         OR_pxl_cnt;

  int checks = 0;
  int failures = 0;
  int img [CIN][ROW][COL];
  int wt  [COUT][CIN][3][3];
  logic checking = 1'b0;
  int posIdx = 0;
  int outIdx = 0;
  int cmpY, cmpX;
  logic [COUT*8-1:0] capAns [NOUT];

  cnn_chip #(
    .PEA_NUM(PEA), .FILTER_NUM(FN), .CIN(CIN), .COUT(COUT),
    .ROW(ROW), .COL(COL), .QSHIFT(QS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .data_in(data_in), .weight_in(weight_in),
    .sum(sum), .sum_reg_valid(sum_reg_valid), .ans(ans),
    .curr_state_or_output(curr_state_or_output), .OR_pxl_cnt(OR_pxl_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the test sequence ended");
    $fatal(1, "[TB] timeout");
  end

  function automatic int chanSum(int o, int c, int y, int x);
    int acc = 0;
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 3; s++)
        if (y+r-1 >= 0 && y+r-1 < ROW && x+s-1 >= 0 && x+s-1 < COL)
          acc += img[c][y+r-1][x+s-1] * wt[o][c][r][s];
    return acc;
  endfunction

  function automatic int qOf(int o, int y, int x);
    int acc = 0;
    for (int c = 0; c < CIN; c++) acc += chanSum(o, c, y, x);
    if (acc < 0) return 0;
    acc = acc >>> QS;
    return (acc > 255) ? 255 : acc;
  endfunction

  function automatic logic [COUT*8-1:0] expAns(int pr, int pc);
    logic [COUT*8-1:0] res = '0;
    for (int o = 0; o < COUT; o++) begin
      int m = 0;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++)
          if (qOf(o, 2*pr+dy, 2*pc+dx) > m) m = qOf(o, 2*pr+dy, 2*pc+dx);
      res[o*8 +: 8] = 8'(m);
    end
    return res;
  endfunction

  function automatic logic [7:0] sat8(int v);
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  function automatic logic [FN*PEA*8-1:0] expSum(int y, int x);
    logic [FN*PEA*8-1:0] res = '0;
    for (int o = 0; o < COUT; o++)
      for (int c = 0; c < CIN; c++)
        res[(o*PEA+c)*8 +: 8] = sat8(chanSum(o, c, y, x));
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkSum(input string name, input logic [FN*PEA*8-1:0] exp);
    int bad = -1;
    checks++;
    for (int i = FN*PEA-1; i >= 0; i--)
      if (sum[i*8 +: 8] !== exp[i*8 +: 8]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("[TB] FAIL %s byte %0d actual=%0h required=%0h", name, bad,
               sum[bad*8 +: 8], exp[bad*8 +: 8]);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=present required=absent", name);
  endtask

  // Model compare: every valid sum and every OUTPUT cycle is checked in stream order.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      if (sum_reg_valid) begin
        if (posIdx < NPIX) begin
          cmpY = 2*((posIdx/4)/(COL/2)) + (posIdx%4)/2;
          cmpX = 2*((posIdx/4)%(COL/2)) + posIdx%2;
          checkSum($sformatf("sum pos(%0d,%0d)", cmpY, cmpX), expSum(cmpY, cmpX));
        end else begin
          reportUnexpected("extraSumValid");
        end
        posIdx++;
      end
      if (curr_state_or_output == 3'd4) begin
        if (outIdx < NOUT) begin
          checkOutput($sformatf("ans%0d", outIdx), ans, expAns(outIdx/(COL/2), outIdx%(COL/2)));
          checkOutput("pxlCntDuringOutput", OR_pxl_cnt, outIdx);
          capAns[outIdx] = ans;
        end else begin
          reportUnexpected("extraOutput");
        end
        outIdx++;
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "State"}, curr_state_or_output, 0);
    checkOutput({tag, "Ans"}, ans, 0);
    checkOutput({tag, "PxlCnt"}, OR_pxl_cnt, 0);
    checkOutput({tag, "Valid"}, sum_reg_valid, 0);
    checkSum({tag, "Sum"}, '0);
  endtask

  task automatic doReset();
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic setFrame(input int dval, input int wval);
    for (int c = 0; c < CIN; c++)
      for (int y = 0; y < ROW; y++)
        for (int x = 0; x < COL; x++) img[c][y][x] = dval;
    for (int o = 0; o < COUT; o++)
      for (int c = 0; c < CIN; c++)
        for (int r = 0; r < 3; r++)
          for (int s = 0; s < 3; s++) wt[o][c][r][s] = wval;
  endtask

  task automatic driveLoad(input int k);
    int y, x, m;
    if (k < 2*COL) begin
      y = k % 2;
      x = k / 2;
    end else begin
      y = 2 + (k - 2*COL) / COL;
      m = (k - 2*COL) % COL;
      x = (y % 2 == 0) ? COL-1-m : m;
    end
    for (int c = 0; c < PEA; c++)
      data_in[c*8 +: 8] = (c < CIN) ? 8'(img[c][y][x]) : 8'($urandom);
    for (int o = 0; o < COUT; o++) begin
      if (k < 3*CIN)
        weight_in[o*24 +: 24] = {8'(wt[o][k/3][k%3][0]), 8'(wt[o][k/3][k%3][1]),
                                 8'(wt[o][k/3][k%3][2])};
      else
        weight_in[o*24 +: 24] = 24'($urandom);
    end
  endtask

  task automatic applyStimulus(input bit holdStart, input int abortAt, input logic [255:0] lastAns);
    posIdx = 0;
    outIdx = 0;
    checking = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checkOutput("armState", curr_state_or_output, 1);
    if (!holdStart) start = 1'b0;
    @(negedge clk);
    checkOutput("loadAfterOneArmCycle", curr_state_or_output, 2);
    for (int k = 0; k < NPIX; k++) begin
      driveLoad(k);
      if (k == abortAt) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("abort");
        start = 1'b0;
        checking = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checkOutput("computeState", curr_state_or_output, 3);
    for (int i = 0; i < 100 && curr_state_or_output != 3'd5; i++) @(negedge clk);
    checkOutput("doneReached", curr_state_or_output, 5);
    checkOutput("positionCount", posIdx, NPIX);
    checkOutput("outputCount", outIdx, NOUT);
    checkOutput("pxlCntFinal", OR_pxl_cnt, NOUT);
    checkOutput("ansHeldAfterLast", ans, lastAns);
    checking = 1'b0;
    if (!holdStart) begin
      @(negedge clk);
      checkOutput("idleAfterDone", curr_state_or_output, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    checkResetState("reset");
    doReset();

    setFrame(1, 1);
    applyStimulus(1'b0, -1, {32{8'h24}});

    // ans still holds 0x24 bytes here, so the abort visibly clears it
    setFrame(1, 1);
    applyStimulus(1'b0, 5, '0);

    setFrame(1, -1);
    applyStimulus(1'b0, -1, '0);
    doReset();

    setFrame(255, 127);
    applyStimulus(1'b0, -1, {32{8'hff}});
    doReset();

    setFrame(0, 0);
    img[0][2][0] = 5;
    wt[0][0][1][1] = 1;
    applyStimulus(1'b0, -1, '0);
    checkOutput("singlePixelThirdAns", capAns[2], 256'h05);
    checkOutput("singlePixelFirstAns", capAns[0], '0);
    doReset();

    setFrame(1, 1);
    applyStimulus(1'b1, -1, {32{8'h24}});
    repeat (3) @(negedge clk);
    checkOutput("doneHeldWhileStartHigh", curr_state_or_output, 5);
    start = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterStartLow", curr_state_or_output, 0);
    start = 1'b1;
    @(negedge clk);
    checkOutput("rearmState", curr_state_or_output, 1);
    start = 1'b0;
    @(negedge clk);
    checkOutput("rearmLastsOneCycle", curr_state_or_output, 2);
    doReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
